// File: rtl/alu_op_fsm_if.sv
// rtl/alu_op_fsm_if.sv - register-bank and ALU bus between alu_op_fsm and its datapath
interface alu_op_fsm_if #(
  parameter int WIDTH = 32,
  parameter int SW    = 3
);
  logic [SW-1:0]    reg_sel;
  logic [WIDTH-1:0] reg_data_in;
  logic             reg_mode;
  logic [WIDTH-1:0] reg_data_out;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [1:0]       alu_s;
  logic [WIDTH-1:0] alu_out;

  modport master (
    output reg_sel, reg_data_in, reg_mode, alu_x, alu_y, alu_s,
    input  reg_data_out, alu_out
  );

  modport slave (
    input  reg_sel, reg_data_in, reg_mode, alu_x, alu_y, alu_s,
    output reg_data_out, alu_out
  );
endinterface

// File: rtl/alu_op_fsm.sv
// rtl/alu_op_fsm.sv - sequences one UM arithmetic instruction: read B, read C, run ALU, write A
module alu_op_fsm #(
  parameter int WIDTH       = 32,
  parameter int NREGS       = 8,
  parameter int ALU_LATENCY = 1,
  parameter int SW          = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    opcode,
  input  logic [SW-1:0] regA,
  input  logic [SW-1:0] regB,
  input  logic [SW-1:0] regC,
  output logic          busy,
  output logic          finished,
  output logic          div_zero,
  output logic          illegal_op,
  alu_op_fsm_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RD_B, RD_C, EXEC, WR_A, DONE} state_t;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);
  localparam logic [1:0] OP_DIV = 2'b10;

  state_t state, state_next;

  logic [SW-1:0]    a_q, b_q, c_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q, res_q;
  logic [WIDTH-1:0] alu_x_q, alu_y_q;
  logic [1:0]       alu_s_q;
  logic [3:0]       cnt_q;
  logic             div_zero_q, illegal_q;

  logic             opcode_legal;
  logic             y_is_zero;
  logic [SW-1:0]    reg_sel_c;
  logic [WIDTH-1:0] reg_data_in_c;
  logic             reg_mode_c;

  assign opcode_legal = (opcode >= 4'd3) && (opcode <= 4'd6);
  assign y_is_zero    = (bus.reg_data_out == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b1;
    finished      = 1'b0;
    reg_sel_c     = '0;
    reg_data_in_c = '0;
    reg_mode_c    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = opcode_legal ? RD_B : DONE;
      end
      RD_B: begin
        reg_sel_c  = b_q;
        state_next = RD_C;
      end
      RD_C: begin
        reg_sel_c  = c_q;
        state_next = (op_q == OP_DIV && y_is_zero) ? DONE : EXEC;
      end
      EXEC: begin
        if (cnt_q <= 4'd1) state_next = WR_A;
      end
      WR_A: begin
        reg_sel_c     = a_q;
        reg_data_in_c = res_q;
        reg_mode_c    = 1'b1;
        state_next    = DONE;
      end
      DONE: begin
        finished   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU operand registers load only on entry to EXEC so they hold between instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      res_q      <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_s_q    <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_zero_q <= 1'b0;
            illegal_q  <= ~opcode_legal;
            if (opcode_legal) begin
              a_q  <= regA;
              b_q  <= regB;
              c_q  <= regC;
              op_q <= opcode[1:0] + 2'd1;
            end
          end
        end
        RD_B: x_q <= bus.reg_data_out;
        RD_C: begin
          y_q <= bus.reg_data_out;
          if (op_q == OP_DIV && y_is_zero) begin
            div_zero_q <= 1'b1;
          end else begin
            cnt_q   <= LAT;
            alu_x_q <= x_q;
            alu_y_q <= bus.reg_data_out;
            alu_s_q <= op_q;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) res_q <= bus.alu_out;
        end
        default: ;
      endcase
    end
  end

  assign div_zero        = div_zero_q;
  assign illegal_op      = illegal_q;
  assign bus.reg_sel     = reg_sel_c;
  assign bus.reg_data_in = reg_data_in_c;
  assign bus.reg_mode    = reg_mode_c;
  assign bus.alu_x       = alu_x_q;
  assign bus.alu_y       = alu_y_q;
  assign bus.alu_s       = alu_s_q;

endmodule

// File: tb/tb_alu_op_fsm.sv
// tb/tb_alu_op_fsm.sv - directed self-checking bench for alu_op_fsm at latency 1 and 3
module tb_alu_op_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [3:0]  opcode = '0;
  logic [2:0]  ra = '0, rb = '0, rc = '0;
  logic        busy1, fin1, dz1, il1;
  logic        busy3, fin3, dz3, il3;

  logic        pl_en1 = 1'b0, pl_en3 = 1'b0;
  logic [2:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  logic [31:0] bank1 [8];
  logic [31:0] bank3 [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_fsm_if #(.WIDTH(32), .SW(3)) if1 ();
  alu_op_fsm_if #(.WIDTH(32), .SW(3)) if3 ();

  alu_op_fsm #(.WIDTH(32), .NREGS(8), .ALU_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .opcode(opcode),
    .regA(ra), .regB(rb), .regC(rc),
    .busy(busy1), .finished(fin1), .div_zero(dz1), .illegal_op(il1),
    .bus(if1.master)
  );

  alu_op_fsm #(.WIDTH(32), .NREGS(8), .ALU_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .opcode(opcode),
    .regA(ra), .regB(rb), .regC(rc),
    .busy(busy3), .finished(fin3), .div_zero(dz3), .illegal_op(il3),
    .bus(if3.master)
  );

  // Register banks and ALUs standing in for the real datapath.
  always_ff @(posedge clk) begin
    if (pl_en1) bank1[pl_idx] <= pl_val;
    else if (if1.reg_mode) bank1[if1.reg_sel] <= if1.reg_data_in;
    if (pl_en3) bank3[pl_idx] <= pl_val;
    else if (if3.reg_mode) bank3[if3.reg_sel] <= if3.reg_data_in;
  end

  assign if1.reg_data_out = bank1[if1.reg_sel];
  assign if3.reg_data_out = bank3[if3.reg_sel];

  function automatic logic [31:0] alu(input logic [1:0] s, input logic [31:0] x, input logic [31:0] y);
    case (s)
      2'b00:   return x + y;
      2'b01:   return x * y;
      2'b10:   return (y == 0) ? 32'd0 : x / y;
      default: return ~(x & y);
    endcase
  endfunction

  assign if1.alu_out = alu(if1.alu_s, if1.alu_x, if1.alu_y);
  assign if3.alu_out = alu(if3.alu_s, if3.alu_x, if3.alu_y);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load(input bit slow, input logic [2:0] idx, input logic [31:0] v);
    @(negedge clk);
    pl_idx = idx;
    pl_val = v;
    if (slow) pl_en3 = 1'b1;
    else      pl_en1 = 1'b1;
    @(posedge clk);
    #1;
    pl_en1 = 1'b0;
    pl_en3 = 1'b0;
  endtask

  task automatic run_op(input bit slow, input logic [3:0] op,
                        input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        output int fin_cyc, output int wr_cnt,
                        output logic dz, output logic il);
    @(negedge clk);
    opcode = op; ra = a; rb = b; rc = c;
    if (slow) start3 = 1'b1;
    else      start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
    fin_cyc = -1; wr_cnt = 0; dz = 1'b0; il = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (slow ? if3.reg_mode : if1.reg_mode) wr_cnt++;
      if (slow ? fin3 : fin1) begin
        fin_cyc = k;
        dz = slow ? dz3 : dz1;
        il = slow ? il3 : il1;
        break;
      end
    end
  endtask

  int   fc, wc, nfin;
  logic dz, il;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_status", 32'({busy1, fin1, dz1, il1, if1.reg_mode}), 32'd0);
    check("rst_sel_din", 32'(if1.reg_sel) | if1.reg_data_in, 32'd0);
    check("rst_alu", if1.alu_x | if1.alu_y | 32'(if1.alu_s), 32'd0);
    #1 reset = 1'b0;

    load(0, 3'd1, 32'h2c2c);
    load(0, 3'd2, 32'h8f8f);
    run_op(0, 4'd3, 3'd0, 3'd1, 3'd2, fc, wc, dz, il);
    check("add_fin_cycle", 32'(fc), 32'd5);
    check("add_writes", 32'(wc), 32'd1);
    check("add_r0", bank1[0], 32'h0000bbbb);
    @(negedge clk);
    check("add_alu_hold_x", if1.alu_x, 32'h2c2c);
    check("add_idle_busy", 32'(busy1), 32'd0);

    load(0, 3'd1, 32'h00010000);
    load(0, 3'd2, 32'h00010000);
    run_op(0, 4'd4, 3'd0, 3'd1, 3'd2, fc, wc, dz, il);
    check("mul_r0", bank1[0], 32'h00000000);
    check("mul_alu_s", 32'(if1.alu_s), 32'd1);

    load(0, 3'd1, 32'hffff0000);
    load(0, 3'd2, 32'h0f0f0f0f);
    run_op(0, 4'd6, 3'd0, 3'd1, 3'd2, fc, wc, dz, il);
    check("nand_r0", bank1[0], 32'hf0f0ffff);
    check("nand_alu_s", 32'(if1.alu_s), 32'd3);

    load(0, 3'd1, 32'd100);
    load(0, 3'd2, 32'd7);
    run_op(0, 4'd5, 3'd3, 3'd1, 3'd2, fc, wc, dz, il);
    check("div_r3", bank1[3], 32'd14);
    check("div_flag_clear", 32'(dz), 32'd0);

    load(0, 3'd1, 32'h5555);
    load(0, 3'd2, 32'h0);
    run_op(0, 4'd5, 3'd0, 3'd1, 3'd2, fc, wc, dz, il);
    check("dz_fin_cycle", 32'(fc), 32'd3);
    check("dz_flag", 32'(dz), 32'd1);
    check("dz_writes", 32'(wc), 32'd0);
    check("dz_r0_kept", bank1[0], 32'hf0f0ffff);

    run_op(0, 4'd9, 3'd0, 3'd1, 3'd2, fc, wc, dz, il);
    check("ill_fin_cycle", 32'(fc), 32'd1);
    check("ill_flag", 32'(il), 32'd1);
    check("ill_dz_cleared", 32'(dz), 32'd0);
    check("ill_writes", 32'(wc), 32'd0);
    check("ill_r0_kept", bank1[0], 32'hf0f0ffff);

    load(0, 3'd1, 32'd1);
    load(0, 3'd2, 32'd2);
    run_op(0, 4'd3, 3'd0, 3'd1, 3'd2, fc, wc, dz, il);
    check("ill_flag_cleared", 32'(il), 32'd0);
    check("add2_r0", bank1[0], 32'd3);

    // Reset in the EXEC cycle must suppress the write to r0.
    load(0, 3'd0, 32'hdeadbeef);
    load(0, 3'd1, 32'd10);
    load(0, 3'd2, 32'd20);
    @(negedge clk);
    opcode = 4'd3; ra = 3'd0; rb = 3'd1; rc = 3'd2; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("exec_alu_x", if1.alu_x, 32'd10);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rstx_status", 32'({busy1, fin1, dz1, il1, if1.reg_mode}), 32'd0);
    check("rstx_alu", if1.alu_x | if1.alu_y | 32'(if1.alu_s), 32'd0);
    repeat (4) @(negedge clk);
    check("rstx_r0_kept", bank1[0], 32'hdeadbeef);

    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    nfin = 0; wc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) start1 = 1'b1;
      if (k == 3) start1 = 1'b0;
      if (fin1) nfin++;
      if (if1.reg_mode) wc++;
    end
    check("busy_start_fins", 32'(nfin), 32'd1);
    check("busy_start_writes", 32'(wc), 32'd1);
    check("busy_start_r0", bank1[0], 32'd30);

    load(0, 3'd1, 32'd5);
    load(0, 3'd2, 32'd7);
    run_op(0, 4'd3, 3'd1, 3'd1, 3'd2, fc, wc, dz, il);
    check("alias_r1", bank1[1], 32'd12);
    check("alias_fin_cycle", 32'(fc), 32'd5);

    load(1, 3'd1, 32'd5);
    load(1, 3'd2, 32'd7);
    run_op(1, 4'd3, 3'd1, 3'd1, 3'd2, fc, wc, dz, il);
    check("lat3_fin_cycle", 32'(fc), 32'd7);
    check("lat3_writes", 32'(wc), 32'd1);
    check("lat3_r1", bank3[1], 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_fsm.md
ALU_OP_FSM -- requirements
Module: alu_op_fsm

Interface
REQ-001 The block SHALL use one clock, `clk`, and a synchronous, active-high reset, `reset`.
REQ-002 Parameter WIDTH, default 32: data path width in bits.
REQ-003 Parameter NREGS, default 8: register-bank depth; SW = $clog2(NREGS).
REQ-004 Parameter ALU_LATENCY, default 1, legal range 1..15: clocks from stable `alu_x`/`alu_y`/`alu_s` to valid `alu_out`.
REQ-005 `clk  in  1`: clock; all state changes on its rising edge.
REQ-006 `reset  in  1`: synchronous active-high reset, sampled on `clk` rise.
REQ-007 `start  in  1`: request to execute the presented instruction.
REQ-008 `opcode  in  4`: UM opcode; 3=add, 4=mul, 5=div, 6=nand.
REQ-009 `regA`/`regB`/`regC  in  SW each`: destination and source register indices.
REQ-010 `reg_data_out  in  WIDTH`: register-bank read data for `reg_sel`, valid combinationally in the same cycle.
REQ-011 `alu_out  in  WIDTH`: ALU result.
REQ-012 `reg_sel  out  SW`, `reg_data_in  out  WIDTH`, `reg_mode  out  1`: register-bank request; `reg_mode` 1=write, 0=read.
REQ-013 `alu_x`/`alu_y  out  WIDTH each` and `alu_s  out  2` (00 add, 01 mul, 10 div, 11 nand): ALU operands and operation select.
REQ-014 `busy  out  1`, `finished  out  1`, `div_zero  out  1`, `illegal_op  out  1`: status outputs.

Function
REQ-015 States: IDLE, RD_B, RD_C, EXEC, WR_A, DONE, encoded in a single state register.
REQ-016 IDLE, `start`=1, legal opcode: latch regA/regB/regC/opcode; next state RD_B.
REQ-017 IDLE, `start`=1, illegal opcode: set `illegal_op`; next state DONE; no register access.
REQ-018 RD_B: drive `reg_sel`=latched B and `reg_mode`=0; latch `reg_data_out` into operand X; next state RD_C.
REQ-019 RD_C: drive `reg_sel`=latched C and `reg_mode`=0; latch operand Y.
REQ-020 RD_C exit: if op=div and Y==0, set `div_zero` and go to DONE; otherwise go to EXEC and load the latency counter with ALU_LATENCY.
REQ-021 EXEC: drive `alu_x`=X, `alu_y`=Y and `alu_s` from the op; the counter decrements each cycle.
REQ-022 EXEC exit: on the cycle the counter reaches 1, latch `alu_out` into the result register and go to WR_A; EXEC therefore lasts exactly ALU_LATENCY cycles.
REQ-023 WR_A: drive `reg_sel`=latched A, `reg_data_in`=result and `reg_mode`=1 for exactly one cycle; next state DONE.
REQ-024 DONE: `finished`=1 for exactly one cycle; next state IDLE.
REQ-025 `div_zero`/`illegal_op` SHALL be valid while `finished`=1 and clear on the next accepted `start`.
REQ-026 `busy`=1 in every state except IDLE; `start` is ignored while busy.
REQ-027 Latency for a legal op with no fault: `start` sampled in cycle 0 -> `finished` in cycle 4+ALU_LATENCY.
REQ-028 Arithmetic is the ALU's, modulo 2^WIDTH: add wraps, mul keeps the low WIDTH bits, div is unsigned floor, nand is bitwise.
REQ-029 A, B and C may alias; reads complete before the write, so the result uses the pre-write values.
REQ-030 `reg_mode`=1 only in WR_A; no register write occurs on div-by-zero or illegal opcode.
REQ-031 Outside EXEC, `alu_x`/`alu_y`/`alu_s` hold their last values (0 after reset).

Reset
REQ-032 `reset`=1 forces IDLE on the next `clk` edge, from any state.
REQ-033 Register values after reset: `busy`=`finished`=`div_zero`=`illegal_op`=`reg_mode`=0; `reg_sel`, `reg_data_in`, `alu_x`, `alu_y`, `alu_s`, counter and operand/result registers all 0.
REQ-034 Reset asserted mid-operation, including the cycle before WR_A, SHALL produce no register write; `start` is ignored while `reset`=1.

Verification (WIDTH=32, NREGS=8, ALU_LATENCY=1)
REQ-035 Add: r1=0x2c2c, r2=0x8f8f; opcode 3, A=0, B=1, C=2; pulse `start` -> r0=0x0000bbbb, `finished` in cycle 5, single write cycle.
REQ-036 Mul wrap: r1=r2=0x00010000, opcode 4 -> r0=0x00000000; then nand with r1=0xffff0000, r2=0x0f0f0f0f -> r0=0xf0f0ffff.
REQ-037 Div-by-zero: r1=0x5555, r2=0, opcode 5 -> `div_zero`=1 with `finished` in cycle 3, r0 unchanged, `reg_mode` never 1.
REQ-038 Illegal opcode 9 -> `illegal_op`=1, `finished` in cycle 1, no register access.
REQ-039 Reset during EXEC -> IDLE next cycle, no write, all outputs at reset values; second `start` while busy -> ignored, only one `finished` pulse.
REQ-040 Aliasing A=B=1, C=2, r1=5, r2=7, add -> r1=12; repeat with ALU_LATENCY=3 -> `finished` in cycle 7.
